rv_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Holds the program counter and issues in-order word fetches to an instruction-memory request/grant/response port. Buffers returned words with their PCs in a small FIFO and presents them to the decoder through a valid/ready handshake. A redirect (taken branch/jump resolved downstream) flushes buffered and in-flight fetches and restarts at the new target.

---
 rtl/rv_pkg.sv | 11 +
 rtl/rv_fetch_fifo.sv | 64 ++++++
 rtl/rv_fetch.sv | 106 ++++++++++
 tb/tb_rv_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_FLUSH} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/rv_fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush; head is read combinationally.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush dominates; a push into a full FIFO is only accepted alongside a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch stage: PC, credit-limited in-order memory fetches, fetch buffer and redirect flush.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit_sum;
  logic          fifo_full, fifo_empty, push, pop, grant_fire;
  logic [31:0]   target;
  fetch_entry_t  head, push_entry;

  // Words already buffered plus words still in flight must fit in the FIFO.
  assign credit_sum  = {1'b0, fifo_cnt} + {1'b0, out_q};
  assign imem_req_o  = (state_q != FS_BOOT) && !fifo_full && (credit_sum < DEPTH_C);
  assign imem_addr_o = pc_q;
  assign grant_fire  = imem_req_o && imem_gnt_i;
  assign target      = {redirect_target_i[31:2], 2'b00};
  assign push_entry  = '{instr: imem_rdata_i, pc: resp_pc_q};
  assign pop         = instr_valid_o && instr_ready_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    disc_d    = disc_q;
    push      = 1'b0;
    out_d     = out_q + CW'(grant_fire) - CW'(imem_rvalid_i);
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      pc_d      = target;
      resp_pc_d = target;
      disc_d    = out_d;
      state_d   = (out_d != '0) ? FS_FLUSH : FS_RUN;
    end else begin
      if (grant_fire) pc_d = pc_q + 32'd4;
      if (imem_rvalid_i) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      case (state_q)
        FS_BOOT:  state_d = FS_RUN;
        FS_FLUSH: if (disc_d == '0) state_d = FS_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FS_BOOT;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
    end
  end

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .count_o     (fifo_cnt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = instr_valid_o ? head.instr : NOP_INSTR;
  assign instr_pc_o    = instr_valid_o ? head.pc : 32'h0;
endmodule

// File: tb/tb_rv_fetch.sv
// Self-checking bench for rv_fetch: directed trace table, corner sequences and randomized stream vs. reference.
module tb_rv_fetch;
  import rv_pkg::*;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  rv_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_ready_i     (instr_ready_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          gnt;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  int          last_due = 0;
  int          pops = 0;
  int          grants = 0;
  logic [31:0] exp_pc;
  pend_t       q[$];

  // Memory contents: an address hash so every word identifies its own address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge: drive memory and decoder,
  // score the instruction stream, then advance.
  task automatic step(input bit g, input bit rdy, input bit redir, input logic [31:0] tgt);
    pend_t p;
    int    l;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memf(q[0].addr);
      void'(q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i = g;
    if (imem_req_o && g) begin
      l        = rand_lat ? int'($urandom_range(1, 4)) : lat;
      last_due = (cyc + l > last_due) ? cyc + l : last_due + 1;
      p.addr   = imem_addr_o;
      p.due    = last_due;
      q.push_back(p);
      grants++;
    end
    chk("outstanding_bound", 64'(q.size() <= FIFO_DEPTH), 64'd1);
    instr_ready_i     = rdy;
    redirect_i        = redir;
    redirect_target_i = tgt;
    if (instr_valid_o) begin
      if (rdy) begin
        chk("pop_pc", instr_pc_o, exp_pc);
        chk("pop_instr", instr_o, memf(exp_pc));
        $display("cycle %0d: pop pc=%08h instr=%08h", cyc, instr_pc_o, instr_o);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end else begin
      chk("idle_outputs", {instr_o, instr_pc_o}, {NOP_INSTR, 32'h0});
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_i             = 1'b1;
    imem_gnt_i        = 1'b0;
    imem_rvalid_i     = 1'b0;
    imem_rdata_i      = '0;
    redirect_i        = 1'b0;
    redirect_target_i = '0;
    instr_ready_i     = 1'b0;
    q.delete();
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, NOP_INSTR);
    chk("rst_pc", instr_pc_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst_i    = 1'b0;
    exp_pc   = RESET_PC;
    last_due = cyc;
    rand_lat = 1'b0;
    lat      = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   g0;
    int   p0;
    int   n;
    bit   g, r, rd;

    // Startup trace with single-cycle memory and an always-ready decoder.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};

    rst_i = 1'b1;
    exp_pc = RESET_PC;
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("tbl%0d_req", i), imem_req_o, tbl[i].exp_req);
      chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid_o, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_pc", i), instr_pc_o, tbl[i].exp_pc);
      step(tbl[i].gnt, tbl[i].rdy, 1'b0, 32'h0);
    end

    // Decoder stalled: exactly FIFO_DEPTH grants, then request drops and head holds.
    apply_reset();
    g0 = grants;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_grants", grants - g0, FIFO_DEPTH);
    chk("stall_req_low", imem_req_o, 0);
    chk("stall_head_valid", instr_valid_o, 1);
    chk("stall_head_pc", instr_pc_o, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_release_progress", 64'(exp_pc >= 32'h8), 64'd1);

    // Three-cycle memory, two fetches in flight, redirect to 0x200.
    apply_reset();
    lat = 3;
    n = 0;
    while (q.size() < 2 && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("two_outstanding", q.size(), 2);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("redir200_addr", imem_addr_o, 32'h200);
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir200_progress", 64'(exp_pc >= 32'h208), 64'd1);

    // Redirect to an unaligned target coinciding with a grant and a response.
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_cycle_req", imem_req_o, 1);
    chk("same_cycle_rsp_due", 64'(q.size() == 1 && q[0].due <= cyc), 64'd1);
    step(1'b1, 1'b1, 1'b1, 32'h103);
    chk("redir103_addr", imem_addr_o, 32'h100);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir103_progress", 64'(exp_pc >= 32'h108), 64'd1);

    // Grant withheld for five cycles: address and PC must not move.
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (5) begin
      chk("nogrant_req", imem_req_o, 1);
      chk("nogrant_addr", imem_addr_o, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("nogrant_addr_after", imem_addr_o, 32'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("nogrant_resume", 64'(exp_pc >= 32'h8), 64'd1);

    // Reset asserted while the buffer holds two entries.
    apply_reset();
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("midrst_valid_before", instr_valid_o, 1);
    apply_reset();
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_restart", 64'(exp_pc >= 32'h8), 64'd1);

    // Randomized memory latency, grant, ready and redirects.
    apply_reset();
    rand_lat = 1'b1;
    p0 = pops;
    repeat (600) begin
      g  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 29) == 0);
      step(g, r, rd, $urandom);
    end
    chk("random_progress", 64'(pops - p0 > 50), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
